// File: rtl/eqgen_pkg.sv
// eqgen_pkg: shared state encoding and constants for the equation generator.
// CHECK exists only when EQGEN_SELFCHECK_EN is defined.
package eqgen_pkg;
  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    FIT_Q,
    FIT_Z,
    BUILD,
`ifdef EQGEN_SELFCHECK_EN
    CHECK,
`endif
    PRESENT
  } state_e;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [2:0]  Z_MAX        = 3'd7;
endpackage

// File: rtl/eqgen_lfsr.sv
// eqgen_lfsr: free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11, loads seed on reset.
module eqgen_lfsr
  import eqgen_pkg::*;
(
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] seed,
  output logic [15:0] out
);
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) out <= seed;
    else out <= {1'b0, out[15:1]} ^ (out[0] ? LFSR_TAPS : 16'h0000);
endmodule

// File: rtl/equation_generator.sv
// equation_generator: builds x,y,z with (x/z)^2 + y/z == T from a random snapshot.
// Define EQGEN_SELFCHECK_EN to add a CHECK state that flags a sticky err on mismatch.
module equation_generator
  import eqgen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       startGen,
  input  logic [6:0] OngoingTimer,
  input  logic       ack,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  output logic [7:0] z_out,
  output logic       valid,
  output logic       busy,
  output logic       err
);
  state_e      state_q, state_d;
  logic [15:0] lfsr;
  logic [6:0]  t_q, t_d, d_q, d_d;
  logic [3:0]  q_q, q_d;
  logic [2:0]  z_q, z_d, zo_q, zo_d;
  logic [1:0]  rx_q, rx_d, ry_q, ry_d, rxc, ryc;
  logic [7:0]  x_q, x_d, y_q, y_d, qq;
  logic [9:0]  fz;
  logic        unused_lfsr;

  eqgen_lfsr u_lfsr (.Clock(Clock), .Resetn(Resetn), .seed(SEED), .out(lfsr));

  assign unused_lfsr = ^{lfsr[15:12], lfsr[7]};
  assign qq  = {4'b0, q_q} * {4'b0, q_q};
  assign fz  = {3'b0, d_q} * {7'b0, z_q} + {7'b0, z_q} - 10'd1;
  assign rxc = ({1'b0, rx_q} >= z_q) ? 2'd0 : rx_q;
  assign ryc = ({1'b0, ry_q} >= z_q) ? 2'd0 : ry_q;

  always_comb begin
    state_d = state_q;
    t_d = t_q;
    d_d = d_q;
    q_d = q_q;
    z_d = z_q;
    zo_d = zo_q;
    rx_d = rx_q;
    ry_d = ry_q;
    x_d = x_q;
    y_d = y_q;
    case (state_q)
      IDLE: state_d = startGen ? CAPTURE : IDLE;
      CAPTURE: begin
        t_d = OngoingTimer;
        q_d = lfsr[3:0];
        z_d = (lfsr[6:4] == 3'd0) ? 3'd1 : lfsr[6:4];
        rx_d = lfsr[9:8];
        ry_d = lfsr[11:10];
        state_d = FIT_Q;
      end
      FIT_Q: begin
        q_d = (qq > {1'b0, t_q}) ? q_q - 4'd1 : q_q;
        d_d = t_q - qq[6:0];
        state_d = (qq > {1'b0, t_q}) ? FIT_Q : FIT_Z;
      end
      FIT_Z: begin
        z_d = (fz > 10'd255) ? z_q - 3'd1 : z_q;
        state_d = (fz > 10'd255) ? FIT_Z : BUILD;
      end
      BUILD: begin
        x_d = {4'b0, q_q} * {5'b0, z_q} + {6'b0, rxc};
        y_d = {1'b0, d_q} * {5'b0, z_q} + {6'b0, ryc};
        zo_d = z_q;
`ifdef EQGEN_SELFCHECK_EN
        state_d = CHECK;
      end
      CHECK: state_d = PRESENT;
`else
        state_d = PRESENT;
      end
`endif
      PRESENT: state_d = ack ? IDLE : PRESENT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state_q <= IDLE;
      t_q <= '0;
      d_q <= '0;
      q_q <= '0;
      z_q <= 3'd1;
      zo_q <= 3'd1;
      rx_q <= '0;
      ry_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      d_q <= d_d;
      q_q <= q_d;
      z_q <= z_d;
      zo_q <= zo_d;
      rx_q <= rx_d;
      ry_q <= ry_d;
      x_q <= x_d;
      y_q <= y_d;
    end

`ifdef EQGEN_SELFCHECK_EN
  logic        err_q, err_d;
  logic [7:0]  xz, yz;
  logic [15:0] chk;
  assign xz    = x_q / {5'b0, zo_q};
  assign yz    = y_q / {5'b0, zo_q};
  assign chk   = {8'b0, xz} * {8'b0, xz} + {8'b0, yz};
  assign err_d = err_q | (state_q == CHECK && chk != {9'b0, t_q});
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) err_q <= 1'b0;
    else err_q <= err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = {5'b0, zo_q};
  assign valid = (state_q == PRESENT);
  assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_equation_generator.sv
// tb_equation_generator: directed checks of the generator against an LFSR-tracking reference model.
module tb_equation_generator;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, ack = 1'b0;
  logic [6:0] tmr = '0;
  logic [7:0] x, y, z;
  logic       valid, busy, err;
  logic [15:0] m_lfsr;
  logic [7:0] ex, ey, ez;
  int tests = 0, fails = 0;

  equation_generator dut (
    .Clock(clk), .Resetn(rst_n), .startGen(start), .OngoingTimer(tmr), .ack(ack),
    .x_out(x), .y_out(y), .z_out(z), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 16'hACE1;
    else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ref_model(input logic [6:0] t, input logic [15:0] l,
                           output logic [7:0] rx_o, ry_o, rz_o, output int lat, output int nq);
    int q, zz, rx, ry, d, nz;
    q = l[3:0]; zz = (l[6:4] == 0) ? 1 : l[6:4]; rx = l[9:8]; ry = l[11:10];
    nq = 0; nz = 0;
    while (q * q > t) begin q--; nq++; end
    d = t - q * q;
    while (d * zz + zz - 1 > 255) begin zz--; nz++; end
    if (rx >= zz) rx = 0;
    if (ry >= zz) ry = 0;
    rx_o = 8'(q * zz + rx); ry_o = 8'(d * zz + ry); rz_o = 8'(zz);
    lat = nq + nz + 4;
`ifdef EQGEN_SELFCHECK_EN
    lat++;
`endif
  endtask

  task automatic do_gen(input logic [6:0] t, input string tag, input int pulse_at);
    int lat, elat, nq, ev;
    @(negedge clk); tmr = t; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ref_model(t, m_lfsr, ex, ey, ez, elat, nq);
    lat = 0;
    do begin
      @(negedge clk); lat++;
      start = (lat == pulse_at);
    end while (!valid && lat < 40);
    start = 1'b0;
    chk({tag, ".valid"}, valid, 1);
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".x"}, x, ex);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".z"}, z, ez);
    ev = (z == 0) ? -1 : (x / z) * (x / z) + y / z;
    chk({tag, ".eval"}, ev, t);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".err"}, err, 0);
  endtask

  task automatic do_ack(input string tag, input logic with_start);
    ack = 1'b1; start = with_start;
    @(negedge clk); ack = 1'b0; start = 1'b0;
    chk({tag, ".ack_valid"}, valid, 0);
    chk({tag, ".ack_busy"}, busy, 0);
    chk({tag, ".retain"}, {x, y, z}, {ex, ey, ez});
    @(negedge clk);
    chk({tag, ".no_restart"}, busy, 0);
  endtask

  initial begin
    logic [6:0] tv [5] = '{7'd127, 7'd100, 7'd1, 7'd57, 7'd13};
    int elat, nq, vcnt;
    repeat (3) @(negedge clk);
    chk("rst.valid", valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.x", x, 0);
    chk("rst.y", y, 0);
    chk("rst.z", z, 1);
    chk("rst.err", err, 0);
    rst_n = 1'b1;

    do_gen(7'd0, "t0", -1);
    chk("t0.x_lt_z", x < z, 1);
    chk("t0.y_lt_z", y < z, 1);
    do_ack("t0", 1'b0);

    for (int i = 0; i < 5; i++) begin
      do_gen(tv[i], $sformatf("t%0d", tv[i]), -1);
      chk($sformatf("t%0d.q_sq", tv[i]), (x / z) * (x / z) <= tv[i], 1);
      do_ack($sformatf("t%0d", tv[i]), i == 4);
    end

    do_gen(7'd42, "hold", -1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); tmr = 7'($urandom);
      chk("hold.stable", {valid, x, y, z}, {1'b1, ex, ey, ez});
    end
    do_ack("hold", 1'b0);

    do_gen(7'd0, "ign", 2);
    do_ack("ign", 1'b0);
    vcnt = 0;
    repeat (40) begin @(negedge clk); vcnt += valid; end
    chk("ign.episodes", vcnt, 0);

    @(negedge clk); tmr = 7'd77; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ref_model(7'd77, m_lfsr, ex, ey, ez, elat, nq);
    repeat (nq + 2) @(negedge clk);
    chk("fitz.busy", busy, 1);
    chk("fitz.valid", valid, 0);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.valid", valid, 0);
    chk("arst.x", x, 0);
    chk("arst.z", z, 1);
    @(negedge clk); rst_n = 1'b1;

    do_gen(7'd99, "post", -1);
    do_ack("post", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
